// File: rtl/rng_tx_scheduler_pkg.sv
// rng_tx_scheduler_pkg
//   Shared types and constants for the RNG transmit scheduler: TX FSM state
//   encoding, debug counter widths and a saturating increment helper.
package rng_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_e;

  localparam int DROP_CNT_W = 16;
  localparam int SENT_CNT_W = 16;

  function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rng_tx_scheduler_if.sv
// rng_tx_scheduler_if
//   Byte handshake between the RNG scheduler and the UART transmitter.
//   tx_start  scheduler -> uart  one-cycle load pulse
//   tx_data   scheduler -> uart  byte, stable from tx_start until tx_busy falls
//   tx_busy   uart -> scheduler  high while the transmitter is shifting
interface rng_tx_scheduler_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/rng_health_rct.sv
// rng_health_rct
//   Continuous repetition-count health test on the sampled entropy stream.
//   clk, reset   system clock, synchronous active-high reset
//   sample_en    a new sample is present on bit_in this cycle
//   bit_in       sampled entropy bit
//   fail         combinational: this sample makes the run length reach REP_LIMIT
module rng_health_rct #(
  parameter int REP_LIMIT = 48
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic bit_in,
  output logic fail
);

  localparam int               CNT_W = $clog2(REP_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(REP_LIMIT);

  logic [CNT_W-1:0] rep_q, rep_d;
  logic             prev_q, prev_d;

  always_comb begin
    rep_d  = rep_q;
    prev_d = prev_q;
    if (sample_en) begin
      prev_d = bit_in;
      // rep_q==0 marks "no previous sample yet", so the first sample starts a run of 1
      if (rep_q == '0 || bit_in != prev_q) begin
        rep_d = CNT_W'(1);
      end else if (rep_q != LIMIT) begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  // Flagged in the same cycle as the offending sample so the top can keep
  // that sample's byte out of the holding buffer.
  assign fail = sample_en && (rep_d == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      rep_q  <= rep_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/rng_tx_scheduler.sv
// rng_tx_scheduler
//   Samples the ring-oscillator entropy bit every SAMPLE_DIV cycles, packs
//   samples MSB-first into bytes, runs the repetition-count health test and
//   hands passing bytes to the UART through a one-byte holding buffer.
//   clk          system clock
//   reset        synchronous active-high reset
//   entropy_bit  synchronised XOR of the ring oscillators
//   tx           byte handshake to the transmitter (master side)
//   alarm        sticky health failure; no new bytes are issued while set
//   disp_word    {dropped[15:0], sent[15:0]}
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | waiting for a held byte and an idle transmitter
//   WAIT_ACK   | tx_start issued, waiting for tx_busy to rise (or time out)
//   WAIT_DONE  | transmitter shifting, waiting for tx_busy to fall
module rng_tx_scheduler #(
  parameter int SAMPLE_DIV  = 1000,
  parameter int REP_LIMIT   = 48,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                entropy_bit,
  rng_tx_scheduler_if.master  tx,
  output logic                alarm,
  output logic [31:0]         disp_word
);

  import rng_tx_scheduler_pkg::*;

  localparam int               DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam int               TMO_W    = $clog2(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  logic [DIV_W-1:0]      div_q, div_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            sreg_q, sreg_d;
  logic [7:0]            hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  tx_state_e             state_q, state_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  tx_start_q, tx_start_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  alarm_q, alarm_d;
  logic [SENT_CNT_W-1:0] sent_q, sent_d;
  logic [DROP_CNT_W-1:0] dropped_q, dropped_d;

  logic       sample_en;
  logic       byte_done;
  logic [7:0] new_byte;
  logic       rct_fail;
  logic       issue;

  rng_health_rct #(
    .REP_LIMIT (REP_LIMIT)
  ) u_rct (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .bit_in    (entropy_bit),
    .fail      (rct_fail)
  );

  // Down-counter: reset value SAMPLE_DIV-1 places the first strobe on the
  // SAMPLE_DIV-th cycle after reset, same as counting 0..SAMPLE_DIV-1.
  assign sample_en = (div_q == '0);

  // sreg only keeps the 7 earlier samples; the 8th completes the byte directly.
  assign new_byte  = {sreg_q, entropy_bit};
  assign byte_done = sample_en && (bit_cnt_q == 3'd7);

  // alarm_d includes a trip happening on this very sample.
  assign alarm_d = alarm_q | rct_fail;
  assign issue   = (state_q == ST_IDLE) && hold_valid_q && !tx.tx_busy && !alarm_d;

  always_comb begin
    div_d        = sample_en ? DIV_LAST : div_q - 1'b1;
    bit_cnt_d    = bit_cnt_q;
    sreg_d       = sreg_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    state_d      = state_q;
    tmo_d        = tmo_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    sent_d       = sent_q;
    dropped_d    = dropped_q;

    if (sample_en) begin
      sreg_d    = new_byte[6:0];
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          tx_start_d = 1'b1;
          tx_data_d  = hold_q;
          sent_d     = sent_q + 1'b1;
          tmo_d      = TMO_LAST;
          state_d    = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (tx.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx.tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      hold_valid_d = 1'b0;
    end

    // A slot freed by this cycle's issue can take the completing byte.
    if (byte_done && !alarm_d) begin
      if (!hold_valid_q || issue) begin
        hold_d       = new_byte;
        hold_valid_d = 1'b1;
      end else begin
        dropped_d = sat_inc_drop(dropped_q);
      end
    end

    if (alarm_d) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= DIV_LAST;
      bit_cnt_q    <= '0;
      sreg_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      state_q      <= ST_IDLE;
      tmo_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      alarm_q      <= 1'b0;
      sent_q       <= '0;
      dropped_q    <= '0;
    end else begin
      div_q        <= div_d;
      bit_cnt_q    <= bit_cnt_d;
      sreg_q       <= sreg_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      alarm_q      <= alarm_d;
      sent_q       <= sent_d;
      dropped_q    <= dropped_d;
    end
  end

  assign tx.tx_start = tx_start_q;
  assign tx.tx_data  = tx_data_q;
  assign alarm       = alarm_q;
  assign disp_word   = {dropped_q, sent_q};

endmodule
